keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan sequencer for the 12-key launchpad keypad. Sits directly upstream of the 12:1 keypad line mux.
//  Drives the mux select (sel_o), samples the mux output (key_in), debounces a single locked key and
//  presents press events as 4-bit key codes to the sound/LED logic over a valid/ready handshake.
// PARAMETERS
//  DWELL_CYCLES    4  clocks sel_o is held per key; key_in is sampled on the last dwell cycle (min 2)
//  DEBOUNCE_SCANS  3  consecutive full scans a key must read stable before a press/release is accepted (min 1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  scan_en      in   1  1 = scanning runs; 0 = halt, sel_o=0, debounce state cleared
//  sel_o        out  4  mux select: sel_o[3:1] = group 0..5, sel_o[0] = bank (0: keys 1-6, 1: keys 7,8,9,0,*,#)
//  key_in       in   1  selected key line from the mux (1 = pressed); groups 6,7 read 0
//  key_code_o   out  4  scan index 0..11: 0-5 = keys 1-6, 6 = 7, 7 = 8, 8 = 9, 9 = 0, 10 = *, 11 = #
//  key_valid_o  out  1  key_code_o holds an unconsumed press event
//  key_ready_i  in   1  consumer accepts the event on a clock edge with key_valid_o & key_ready_i
//  key_held_o   out  1  locked key is debounced-pressed
//  overrun_o    out  1  sticky: press accepted while key_valid_o was still pending
//  clr_ovr_i    in   1  synchronous clear of overrun_o (takes priority over a same-cycle set)
//  key_release_o out 1  event type flag; see CONFIGURATION
// BEHAVIOUR
//  Reset (async): sel_o=0, key_code_o=0, key_valid_o=0, key_held_o=0, overrun_o=0, key_release_o=0,
//   scan index k=0, dwell counter=0, FSM=IDLE, lock cleared.
//  Scan order k=0..11, wraps 11->0. sel_o = {k mod 6, k>=6}, giving 0000,0010,0100,0110,1000,1010,0001,...,1011.
//  Full scan = 12*DWELL_CYCLES clocks.
//  FSM: IDLE -(scan_en)-> SETTLE. SETTLE counts DWELL_CYCLES-1 -> SAMPLE. SAMPLE (1 clk) evaluates key_in,
//   then advances k -> SETTLE. Any state -(!scan_en)-> IDLE at the next edge. A pending key_valid_o/key_code_o
//   is retained.
//  Lock: with no lock, the first key sampled 1 in scan order becomes the candidate. Ties go to the lowest k
//   reached first in the current scan.
//  Debounce (per locked key, once per scan at its sample):
//   - not held: candidate reads 1 -> cnt++, else cnt=0 and the lock drops.
//     cnt==DEBOUNCE_SCANS -> held=1 and press event.
//   - held: key reads 0 -> cnt++, 1 -> cnt=0. cnt==DEBOUNCE_SCANS -> held=0, lock drops, release event.
//   - Other keys are ignored while locked.
//  Press event: key_valid_o rises the clock after the qualifying SAMPLE (latency 1).
//   - If key_valid_o=0: load key_code_o=k.
//   - If key_valid_o=1 and not consumed that same edge: keep the old code, set overrun_o.
//   - Consume and new event on the same edge: load the new code, keep valid=1.
//  key_valid_o and key_code_o are stable while key_ready_i=0. They deassert on the consuming edge.
// CONFIGURATION
//  KEYPAD_RELEASE_EVT_EN defined: release events use the same handshake/overrun rules,
//   with key_release_o=1 alongside the code (0 for presses).
//  Not defined: releases only clear key_held_o and generate no event. key_release_o is tied to 0.
// STRUCTURE
//  keypad_pkg: KEY_COUNT=12, state enum {IDLE,SETTLE,SAMPLE}, key code constants, function idx_to_sel(k).
//  Sub-module keypad_debounce: lock/cnt/held logic, one sample strobe in, press/release pulses out.
//  The top holds the FSM, scan counter and output handshake register.
// TESTING (DWELL_CYCLES=4, DEBOUNCE_SCANS=3, scan period 48 clks)
//  Free run with key_in=0 -> sel_o steps 0000,0010,...,1010,0001,...,1011,0000 every 4 clks; no events.
//  Hold key 5 (k=4, sel 1000) for 3 scans with ready=1 -> key_valid_o one-clk pulse after the 3rd sample,
//   key_code_o=4, key_held_o=1.
//  Key 8 (k=7) toggles every scan for 10 scans -> no event, key_held_o stays 0.
//  Press keys 2 and # together -> code 1 only. Release 2 (3 scans) while # is held
//   -> # locks and yields code 11 three scans later.
//  key_ready_i=0, press 3 then 9 -> key_code_o stays 2, overrun_o=1. Pulse clr_ovr_i -> overrun_o=0.
//  Assert rst_n=0 mid-SETTLE with key_held_o=1 -> all outputs 0 immediately. Scan restarts at k=0 after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key codes and scan-index to mux-select mapping for the keypad scanner
package keypad_pkg;

  localparam int KEY_COUNT = 12;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} scan_state_t;

  localparam logic [3:0] KEY_CODE_1    = 4'd0;
  localparam logic [3:0] KEY_CODE_2    = 4'd1;
  localparam logic [3:0] KEY_CODE_3    = 4'd2;
  localparam logic [3:0] KEY_CODE_4    = 4'd3;
  localparam logic [3:0] KEY_CODE_5    = 4'd4;
  localparam logic [3:0] KEY_CODE_6    = 4'd5;
  localparam logic [3:0] KEY_CODE_7    = 4'd6;
  localparam logic [3:0] KEY_CODE_8    = 4'd7;
  localparam logic [3:0] KEY_CODE_9    = 4'd8;
  localparam logic [3:0] KEY_CODE_0    = 4'd9;
  localparam logic [3:0] KEY_CODE_STAR = 4'd10;
  localparam logic [3:0] KEY_CODE_HASH = 4'd11;

  // Bank 0 holds indices 0-5, bank 1 holds 6-11; select is {group, bank}.
  function automatic logic [3:0] idx_to_sel(input logic [3:0] k);
    logic [2:0] g;
    logic       bank;
    bank = (k >= 4'd6);
    g    = bank ? 3'(k - 4'd6) : k[2:0];
    return {g, bank};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - single-key lock and scan-count debouncer producing press/release event pulses
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sample,
  input  logic [3:0] k,
  input  logic       key_in,
  output logic       held,
  output logic       evt,
  output logic       evt_release
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_SCANS);

  logic          locked_q, locked_d;
  logic [3:0]    lock_k_q, lock_k_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          held_q, held_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      lock_k_q <= 4'd0;
      cnt_q    <= '0;
      held_q   <= 1'b0;
    end else begin
      locked_q <= locked_d;
      lock_k_q <= lock_k_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
    end
  end

  // With no lock, any sampled key may become the candidate; once locked only that key is evaluated.
  always_comb begin
    locked_d    = locked_q;
    lock_k_d    = lock_k_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    evt         = 1'b0;
    evt_release = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    if (clear) begin
      locked_d = 1'b0;
      lock_k_d = 4'd0;
      cnt_d    = '0;
      held_d   = 1'b0;
    end else if (sample && (!locked_q || k == lock_k_q)) begin
      if (!held_q) begin
        if (key_in) begin
          locked_d = 1'b1;
          lock_k_d = k;
          if (cnt_inc == TARGET) begin
            held_d = 1'b1;
            cnt_d  = '0;
            evt    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          locked_d = 1'b0;
          cnt_d    = '0;
        end
      end else if (!key_in) begin
        if (cnt_inc == TARGET) begin
          held_d      = 1'b0;
          locked_d    = 1'b0;
          cnt_d       = '0;
          evt         = 1'b1;
          evt_release = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign held = held_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - keypad scan FSM, scan index and event handshake; KEYPAD_RELEASE_EVT_EN enables release events
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES   = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  output logic [3:0] sel_o,
  input  logic       key_in,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       key_held_o,
  output logic       overrun_o,
  input  logic       clr_ovr_i,
  output logic       key_release_o
);

  localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES - 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 2);
  localparam logic [3:0]    K_LAST     = 4'(KEY_COUNT - 1);

  scan_state_t   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    k_q, k_d;
  logic          sample, evt, evt_release, new_evt, new_rel, consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dwell_q <= '0;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        dwell_d = '0;
        k_d     = 4'd0;
        if (scan_en) state_d = SETTLE;
      end
      SETTLE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = SAMPLE;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      SAMPLE: begin
        state_d = SETTLE;
        k_d     = (k_q == K_LAST) ? 4'd0 : k_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (!scan_en) begin
      state_d = IDLE;
      dwell_d = '0;
      k_d     = 4'd0;
    end
  end

  assign sel_o  = (state_q == IDLE) ? 4'd0 : idx_to_sel(k_q);
  assign sample = (state_q == SAMPLE) && scan_en;

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!scan_en),
    .sample     (sample),
    .k          (k_q),
    .key_in     (key_in),
    .held       (key_held_o),
    .evt        (evt),
    .evt_release(evt_release)
  );

`ifdef KEYPAD_RELEASE_EVT_EN
  assign new_evt = evt;
  assign new_rel = evt_release;
`else
  assign new_evt = evt & ~evt_release;
  assign new_rel = 1'b0;
`endif

  assign consume = key_valid_o & key_ready_i;

  // A new event may replace one consumed on the same edge; otherwise a pending event wins and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_o <= 1'b0;
      key_code_o  <= 4'd0;
      overrun_o   <= 1'b0;
    end else begin
      if (consume) key_valid_o <= 1'b0;
      if (new_evt && (!key_valid_o || consume)) begin
        key_valid_o <= 1'b1;
        key_code_o  <= k_q;
      end
      if (clr_ovr_i)
        overrun_o <= 1'b0;
      else if (new_evt && key_valid_o && !consume)
        overrun_o <= 1'b1;
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      key_release_o <= 1'b0;
    else if (new_evt && (!key_valid_o || consume))
      key_release_o <= new_rel;
  end
`else
  assign key_release_o = new_rel;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl with a 12:1 keypad mux model
module tb_keypad_scan_ctrl;

  localparam int SCAN = 48;

  logic       clk = 1'b0;
  logic       rst_n, scan_en, key_in, key_ready_i, clr_ovr_i;
  logic [3:0] sel_o, key_code_o;
  logic       key_valid_o, key_held_o, overrun_o, key_release_o;
  logic [11:0] keys;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.DWELL_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_en      (scan_en),
    .sel_o        (sel_o),
    .key_in       (key_in),
    .key_code_o   (key_code_o),
    .key_valid_o  (key_valid_o),
    .key_ready_i  (key_ready_i),
    .key_held_o   (key_held_o),
    .overrun_o    (overrun_o),
    .clr_ovr_i    (clr_ovr_i),
    .key_release_o(key_release_o)
  );

  // Keypad mux: groups 6 and 7 read 0.
  function automatic logic key_line(input logic [3:0] s, input logic [11:0] kv);
    int idx;
    if (s[3:1] >= 3'd6) return 1'b0;
    idx = int'(s[3:1]) + (s[0] ? 6 : 0);
    return kv[idx];
  endfunction

  assign key_in = key_line(sel_o, keys);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_evt(input logic rel, input logic [3:0] code);
    exp_q.push_back({rel, code});
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [3:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sel_o == v) found = 1'b1;
    end
    check("wait_sel_found", int'(found), 1);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && key_valid_o && key_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event_code", int'(key_code_o), -1);
      end else begin
        e = exp_q.pop_front();
        check("event_code", int'(key_code_o), int'(e[3:0]));
        check("event_release_flag", int'(key_release_o), int'(e[4]));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] sel_tbl [12];

  initial begin
    sel_tbl = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010,
                4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1011};
    rst_n = 1'b0; scan_en = 1'b0; key_ready_i = 1'b1; clr_ovr_i = 1'b0; keys = '0;
    #2;
    check("reset_sel", int'(sel_o), 0);
    check("reset_code", int'(key_code_o), 0);
    check("reset_valid", int'(key_valid_o), 0);
    check("reset_held", int'(key_held_o), 0);
    check("reset_overrun", int'(overrun_o), 0);
    check("reset_release", int'(key_release_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 scan_en = 1'b1;

    // Free run: select steps every 4 clocks, wrapping 11 -> 0.
    @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("free_run_sel", int'(sel_o), int'(sel_tbl[i % 12]));
      repeat (4) @(posedge clk);
    end
    #1;

    // Key 5 held three scans.
    push_evt(1'b0, 4'd4);
    keys[4] = 1'b1;
    wait_scans(4);
    check("key5_held", int'(key_held_o), 1);
`ifdef KEYPAD_RELEASE_EVT_EN
    push_evt(1'b1, 4'd4);
`endif
    keys[4] = 1'b0;
    wait_scans(4);
    check("key5_released", int'(key_held_o), 0);

    // Key 8 toggling every scan never qualifies.
    for (int i = 0; i < 10; i++) begin
      keys[7] = ~keys[7];
      wait_scans(1);
    end
    keys[7] = 1'b0;
    check("key8_bounce_held", int'(key_held_o), 0);
    wait_scans(1);

    // Keys 2 and # together: 2 wins, then # takes over once 2 releases.
    wait_sel(4'b0000);
    push_evt(1'b0, 4'd1);
    keys[1] = 1'b1; keys[11] = 1'b1;
    wait_scans(4);
    check("key2_held", int'(key_held_o), 1);
`ifdef KEYPAD_RELEASE_EVT_EN
    push_evt(1'b1, 4'd1);
`endif
    push_evt(1'b0, 4'd11);
    keys[1] = 1'b0;
    wait_scans(8);
    check("hash_held", int'(key_held_o), 1);
`ifdef KEYPAD_RELEASE_EVT_EN
    push_evt(1'b1, 4'd11);
`endif
    keys[11] = 1'b0;
    wait_scans(4);
    check("hash_released", int'(key_held_o), 0);

    // Consumer stalled: press 3 then 9, first code kept, overrun flagged.
    key_ready_i = 1'b0;
    push_evt(1'b0, 4'd2);
    keys[2] = 1'b1;
    wait_scans(4);
    keys[2] = 1'b0;
    wait_scans(4);
    keys[8] = 1'b1;
    wait_scans(4);
    check("stall_code", int'(key_code_o), 2);
    check("stall_valid", int'(key_valid_o), 1);
    check("stall_overrun", int'(overrun_o), 1);
    clr_ovr_i = 1'b1;
    @(posedge clk); #1 clr_ovr_i = 1'b0;
    check("overrun_cleared", int'(overrun_o), 0);
    key_ready_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("after_consume_valid", int'(key_valid_o), 0);
`ifdef KEYPAD_RELEASE_EVT_EN
    push_evt(1'b1, 4'd8);
`endif
    keys[8] = 1'b0;
    wait_scans(4);
    check("key9_released", int'(key_held_o), 0);

    // Async reset mid-SETTLE while a key is held.
    push_evt(1'b0, 4'd0);
    keys[0] = 1'b1;
    wait_scans(4);
    check("key1_held", int'(key_held_o), 1);
    wait_sel(4'b0010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_sel", int'(sel_o), 0);
    check("mid_reset_held", int'(key_held_o), 0);
    check("mid_reset_valid", int'(key_valid_o), 0);
    check("mid_reset_code", int'(key_code_o), 0);
    check("mid_reset_overrun", int'(overrun_o), 0);
    keys = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_sel_k0", int'(sel_o), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("restart_sel_k1", int'(sel_o), 2);

    wait_scans(1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
